// File: rtl/rv32_pkg.sv
// Shared RV32I constants used across the pipeline stages.
package rv32_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RV32_NOP         = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Drop the low two bits: fetch addresses are always word aligned,
    // misaligned targets are silently truncated rather than trapped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_hold_buf.sv
// Hold/skid buffer for the fetch stage. Captures the SRAM word that
// returns during the first stalled cycle so it survives until the stall
// releases, and muxes the instruction presented to IF/ID.
module if_hold_buf
    import rv32_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         capture_i,  // stalled with a live request outstanding
    input  logic         clear_i,    // IF/ID consumes this cycle (normal or flush)
    input  logic         valid_i,    // presented slot is real, not a bubble
    input  logic [W-1:0] rdata_i,    // SRAM read data
    output logic [W-1:0] inst_o
);

    logic [W-1:0] hold_q, hold_d;
    logic         hold_valid_q, hold_valid_d;

    // Capture only the first word of a stall; later stall cycles see garbage.
    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (capture_i && !hold_valid_q) begin
            hold_d       = rdata_i;
            hold_valid_d = 1'b1;
        end else if (clear_i) begin
            hold_valid_d = 1'b0;
        end
    end

    // Hold state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    // Held word wins over live SRAM data; bubbles are forced to NOP.
    always_comb begin
        if (!valid_i) begin
            inst_o = W'(RV32_NOP);
        end else if (hold_valid_q) begin
            inst_o = hold_q;
        end else begin
            inst_o = rdata_i;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, issues one fetch per
// unstalled cycle to a one-cycle-latency SRAM, redirects on flush, and
// presents the returned instruction to the IF/ID register.
// Cycle priority is reset > flush > stall > normal.
module if_fetch_stage
    import rv32_pkg::*;
#(
    parameter int              XLEN     = rv32_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            im_cs_o,
    output logic [XLEN-1:0] im_addr_o,
    input  logic [XLEN-1:0] im_rdata_i,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_inst_o,
    output logic            if_valid_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            req_valid_q, req_valid_d;
    logic [XLEN-1:0] target_pc;
    logic            fetch_en;
    logic [XLEN-1:0] fetch_addr;
    logic            hold_capture;
    logic            hold_clear;

    assign target_pc = {redirect_pc_i[XLEN-1:2], 2'b00};

    // Next PC / request tracking and the SRAM request for this cycle.
    always_comb begin
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        req_valid_d  = req_valid_q;
        fetch_en     = 1'b0;
        fetch_addr   = pc_q;
        hold_capture = 1'b0;
        hold_clear   = 1'b0;
        if (flush_i) begin
            fetch_en    = 1'b1;
            fetch_addr  = target_pc;
            req_pc_d    = target_pc;
            req_valid_d = 1'b1;
            pc_d        = target_pc + XLEN'(4);
            hold_clear  = 1'b1;
        end else if (stall_i) begin
            hold_capture = req_valid_q;
        end else begin
            fetch_en    = 1'b1;
            req_pc_d    = pc_q;
            req_valid_d = 1'b1;
            pc_d        = pc_q + XLEN'(4);
            hold_clear  = 1'b1;
        end
    end

    // PC and outstanding-request registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
        end
    end

    // Outputs; reset masks everything so stale state never leaks out.
    always_comb begin
        im_cs_o    = fetch_en & ~rst_i;
        im_addr_o  = fetch_addr;
        if_valid_o = req_valid_q & ~flush_i & ~rst_i;
        if_pc_o    = rst_i ? '0 : req_pc_q;
    end

    if_hold_buf #(
        .W(XLEN)
    ) u_hold_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .capture_i (hold_capture),
        .clear_i   (hold_clear),
        .valid_i   (if_valid_o),
        .rdata_i   (im_rdata_i),
        .inst_o    (if_inst_o)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a behavioural SRAM and a
// scoreboard of issued-but-not-yet-consumed fetches.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        im_cs_o;
    logic [31:0] im_addr_o;
    logic [31:0] im_rdata_i = '0;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;

    logic [31:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    if_fetch_stage dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_pc_i (redirect_pc_i),
        .im_cs_o       (im_cs_o),
        .im_addr_o     (im_addr_o),
        .im_rdata_i    (im_rdata_i),
        .if_pc_o       (if_pc_o),
        .if_inst_o     (if_inst_o),
        .if_valid_o    (if_valid_o)
    );

    // Clock
    always #5 clk = ~clk;

    // Instruction memory contents, distinct per word.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        if (a == 32'h8) return 32'hAAAA_0013;
        return {a[31:2] ^ 30'h0123_4567, 2'b11};
    endfunction

    // One-cycle-latency SRAM; returns garbage when not selected.
    always @(posedge clk) begin
        if (im_cs_o) im_rdata_i <= inst_of(im_addr_o);
        else         im_rdata_i <= $urandom();
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check one cycle at the negedge, update scoreboard, advance past posedge.
    task automatic step(input string tag, input logic e_cs, input logic [31:0] e_addr,
                        input logic chk_addr, input logic e_valid);
        logic [31:0] exp_pc;
        @(negedge clk);
        chk({tag, "/cs"}, {31'b0, im_cs_o}, {31'b0, e_cs});
        if (chk_addr) chk({tag, "/addr"}, im_addr_o, e_addr);
        chk({tag, "/valid"}, {31'b0, if_valid_o}, {31'b0, e_valid});
        if (rst_i) begin
            chk({tag, "/rst_pc"}, if_pc_o, 32'h0);
            exp_q.delete();
        end
        if (e_valid) begin
            if (exp_q.size() == 0) begin
                chk({tag, "/sb_empty"}, 32'h1, 32'h0);
            end else begin
                exp_pc = exp_q[0];
                chk({tag, "/pc"}, if_pc_o, exp_pc);
                chk({tag, "/inst"}, if_inst_o, inst_of(exp_pc));
                if (!stall_i) void'(exp_q.pop_front());
            end
        end else begin
            chk({tag, "/nop"}, if_inst_o, NOP);
            if (flush_i && exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (e_cs && !rst_i) exp_q.push_back(e_addr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for two cycles
        step("rst0", 1'b0, 32'h0, 1'b0, 1'b0);
        step("rst1", 1'b0, 32'h0, 1'b0, 1'b0);
        rst_i = 1'b0;

        // Reset release, straight-line fetch
        step("run0", 1'b1, 32'h0, 1'b1, 1'b0);
        step("run1", 1'b1, 32'h4, 1'b1, 1'b1);
        step("run2", 1'b1, 32'h8, 1'b1, 1'b1);

        // Three-cycle stall while presenting PC 0x8
        stall_i = 1'b1;
        step("stall0", 1'b0, 32'hC, 1'b1, 1'b1);
        step("stall1", 1'b0, 32'hC, 1'b1, 1'b1);
        step("stall2", 1'b0, 32'hC, 1'b1, 1'b1);
        stall_i = 1'b0;
        step("release", 1'b1, 32'hC, 1'b1, 1'b1);
        step("after_rel", 1'b1, 32'h10, 1'b1, 1'b1);

        // Flush wins over stall
        stall_i = 1'b1;
        flush_i = 1'b1;
        redirect_pc_i = 32'h100;
        step("flush", 1'b1, 32'h100, 1'b1, 1'b0);
        stall_i = 1'b0;
        flush_i = 1'b0;
        step("tgt0", 1'b1, 32'h104, 1'b1, 1'b1);
        step("tgt1", 1'b1, 32'h108, 1'b1, 1'b1);

        // Misaligned redirect is truncated
        flush_i = 1'b1;
        redirect_pc_i = 32'h103;
        step("mis_flush", 1'b1, 32'h100, 1'b1, 1'b0);
        flush_i = 1'b0;
        step("mis_tgt", 1'b1, 32'h104, 1'b1, 1'b1);

        // PC wraparound at the top of the address space
        flush_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step("wrap_flush", 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        flush_i = 1'b0;
        step("wrap0", 1'b1, 32'h0, 1'b1, 1'b1);
        step("wrap1", 1'b1, 32'h4, 1'b1, 1'b1);

        // Reset during a stall with a held instruction
        stall_i = 1'b1;
        step("hstall0", 1'b0, 32'h8, 1'b1, 1'b1);
        step("hstall1", 1'b0, 32'h8, 1'b1, 1'b1);
        rst_i = 1'b1;
        step("mid_rst", 1'b0, 32'h0, 1'b0, 1'b0);
        rst_i = 1'b0;
        // Stall with no request outstanding captures nothing
        step("post_rst_stall", 1'b0, 32'h0, 1'b1, 1'b0);
        stall_i = 1'b0;
        step("restart0", 1'b1, 32'h0, 1'b1, 1'b0);
        step("restart1", 1'b1, 32'h4, 1'b1, 1'b1);
        step("restart2", 1'b1, 32'h8, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
